// File: rtl/mipi_rx_burst_sequencer.sv
// CSI-2 4-lane receive burst sequencer: aligner reset control, packet header
// parsing, long-packet payload tracking, frame/line counters and error pulses.
module mipi_rx_burst_sequencer #(
  parameter int unsigned SETTLE_CYCLES   = 4,
  parameter int unsigned WATCHDOG_CYCLES = 4096
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        hs_active_i,
  input  logic        lane_valid_i,
  input  logic [31:0] lane_data_i,
  output logic        aligner_reset_o,
  output logic        frame_active_o,
  output logic        line_active_o,
  output logic [5:0]  data_type_o,
  output logic [15:0] line_count_o,
  output logic [15:0] last_frame_lines_o,
  output logic [15:0] frame_count_o,
  output logic        err_timeout_o,
  output logic        err_truncated_o,
  output logic        err_sequence_o
);

  localparam logic [7:0]  SETTLE_LIM = 8'(SETTLE_CYCLES);
  localparam logic [15:0] WD_LIM     = 16'(WATCHDOG_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    WAIT_HDR,
    PAYLOAD,
    TRAIL
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  settle_q, settle_d;
  logic [15:0] wd_q, wd_d;
  logic [14:0] beats_q, beats_d;

  logic        aligner_reset_d, frame_active_d, line_active_d;
  logic [5:0]  data_type_d;
  logic [15:0] line_count_d, last_frame_lines_d, frame_count_d;
  logic        err_timeout_d, err_truncated_d, err_sequence_d;

  logic [5:0]  hdr_type;
  logic [16:0] wc_plus_crc;
  logic        unused_hdr_bits;

  assign hdr_type        = lane_data_i[5:0];
  assign wc_plus_crc     = {1'b0, lane_data_i[23:8]} + 17'd5;
  assign unused_hdr_bits = ^{lane_data_i[31:24], lane_data_i[7:6]};

  always_comb begin
    state_d            = state_q;
    settle_d           = settle_q;
    wd_d               = wd_q;
    beats_d            = beats_q;
    frame_active_d     = frame_active_o;
    line_active_d      = line_active_o;
    data_type_d        = data_type_o;
    line_count_d       = line_count_o;
    last_frame_lines_d = last_frame_lines_o;
    frame_count_d      = frame_count_o;
    err_timeout_d      = 1'b0;
    err_truncated_d    = 1'b0;
    err_sequence_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (hs_active_i) begin
          state_d  = SETTLE;
          settle_d = '0;
        end
      end

      SETTLE: begin
        if (!hs_active_i) begin
          state_d = IDLE;
        end else if (settle_q == SETTLE_LIM) begin
          state_d = WAIT_HDR;
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end

      WAIT_HDR: begin
        if (!hs_active_i) begin
          state_d = IDLE;
        end else if (lane_valid_i) begin
          wd_d = '0;
          if (hdr_type == 6'h00) begin
            err_sequence_d = frame_active_o;
            frame_active_d = 1'b1;
            line_count_d   = '0;
            state_d        = TRAIL;
          end else if (hdr_type == 6'h01) begin
            if (frame_active_o) begin
              frame_active_d     = 1'b0;
              last_frame_lines_d = line_count_o;
              frame_count_d      = frame_count_o + 16'd1;
            end else begin
              err_sequence_d = 1'b1;
            end
            state_d = TRAIL;
          end else if (hdr_type < 6'h10) begin
            state_d = TRAIL;
          end else begin
            // Beat count covers payload plus the 2-byte CRC, rounded up to words.
            data_type_d   = hdr_type;
            beats_d       = wc_plus_crc[16:2];
            line_active_d = 1'b1;
            state_d       = PAYLOAD;
          end
        end else if (wd_q == WD_LIM) begin
          err_timeout_d = 1'b1;
          state_d       = TRAIL;
        end else begin
          wd_d = wd_q + 16'd1;
        end
      end

      PAYLOAD: begin
        // A final beat completes the line even if HS drops or the watchdog
        // would expire on the same edge.
        if (lane_valid_i && beats_q == 15'd1) begin
          line_active_d = 1'b0;
          if (frame_active_o) begin
            line_count_d = line_count_o + 16'd1;
          end
          state_d = TRAIL;
        end else if (!hs_active_i) begin
          err_truncated_d = 1'b1;
          line_active_d   = 1'b0;
          state_d         = IDLE;
        end else if (lane_valid_i) begin
          beats_d = beats_q - 15'd1;
          wd_d    = '0;
        end else if (wd_q == WD_LIM) begin
          err_timeout_d = 1'b1;
          line_active_d = 1'b0;
          state_d       = TRAIL;
        end else begin
          wd_d = wd_q + 16'd1;
        end
      end

      TRAIL: begin
        if (!hs_active_i) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d       = IDLE;
        line_active_d = 1'b0;
      end
    endcase

    if (state_d != state_q) begin
      wd_d = '0;
    end

    aligner_reset_d = !(state_d == WAIT_HDR || state_d == PAYLOAD);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q            <= IDLE;
      settle_q           <= '0;
      wd_q               <= '0;
      beats_q            <= '0;
      aligner_reset_o    <= 1'b1;
      frame_active_o     <= 1'b0;
      line_active_o      <= 1'b0;
      data_type_o        <= '0;
      line_count_o       <= '0;
      last_frame_lines_o <= '0;
      frame_count_o      <= '0;
      err_timeout_o      <= 1'b0;
      err_truncated_o    <= 1'b0;
      err_sequence_o     <= 1'b0;
    end else begin
      state_q            <= state_d;
      settle_q           <= settle_d;
      wd_q               <= wd_d;
      beats_q            <= beats_d;
      aligner_reset_o    <= aligner_reset_d;
      frame_active_o     <= frame_active_d;
      line_active_o      <= line_active_d;
      data_type_o        <= data_type_d;
      line_count_o       <= line_count_d;
      last_frame_lines_o <= last_frame_lines_d;
      frame_count_o      <= frame_count_d;
      err_timeout_o      <= err_timeout_d;
      err_truncated_o    <= err_truncated_d;
      err_sequence_o     <= err_sequence_d;
    end
  end

endmodule

// File: doc/mipi_rx_burst_sequencer.md
# mipi_rx_burst_sequencer

Sequencer for the 4-lane CSI-2 receive path, clocked by the PHY byte clock. Watches the HS state of the lanes and the lane-aligned 32-bit words. From these it drives the byte/lane aligner reset, parses packet headers, and tracks each long-packet payload. It generates the frame/line sync, line/frame counters and error pulses that the decoder, depacker, debayer and output reformatter previously took from external pins.

## Interface
- SETTLE_CYCLES, 4: byte clocks after HS entry before releasing aligner reset (1..255).
- WATCHDOG_CYCLES, 4096: idle byte clocks tolerated inside a burst before abort (2..65535).
- clk_i  input  1  MIPI byte clock; single clock domain.
- reset_n_i  input  1  asynchronous, active-low reset.
- hs_active_i  input  1  high while data lanes are in HS mode (synchronous to clk_i).
- lane_valid_i  input  1  lane aligner output word valid.
- lane_data_i  input  32  lane-aligned word; header word: [7:0] data ID, [23:8] word count, [31:24] ECC.
- aligner_reset_o  output  1  active-high reset to byte and lane aligners.
- frame_active_o  output  1  high between frame-start and frame-end short packets.
- line_active_o  output  1  high while a long-packet payload is in flight.
- data_type_o  output  6  data type of current/last long packet.
- line_count_o  output  16  long packets received in current frame.
- last_frame_lines_o  output  16  line_count_o latched at frame end.
- frame_count_o  output  16  completed frames, wraps.
- err_timeout_o  output  1  one-cycle pulse, watchdog abort.
- err_truncated_o  output  1  one-cycle pulse, HS dropped mid-payload.
- err_sequence_o  output  1  one-cycle pulse, frame start while frame active or frame end while inactive.

## Operation
- States: IDLE, SETTLE, WAIT_HDR, PAYLOAD, TRAIL.
- IDLE: aligner_reset_o=1. hs_active_i=1 -> SETTLE, settle counter cleared.
- SETTLE: aligner_reset_o=1. Count SETTLE_CYCLES cycles of hs_active_i=1, then -> WAIT_HDR. hs_active_i=0 -> IDLE (no error).
- WAIT_HDR: aligner_reset_o=0. First lane_valid_i=1 word is the header; data type = lane_data_i[5:0].
  - 0x00 frame start: frame_active_o<=1, line_count_o<=0. If already active, pulse err_sequence_o and still restart the count. -> TRAIL.
  - 0x01 frame end: if active, frame_active_o<=0, last_frame_lines_o<=line_count_o, frame_count_o+=1. If inactive, pulse err_sequence_o only. -> TRAIL.
  - Other types 0x02-0x0F (short): -> TRAIL, no effect.
  - Type >=0x10 (long): data_type_o<=type, load beat counter with (WC+5)>>2 (payload plus 2-byte CRC; 17-bit sum, WC=0 gives 1 beat). -> PAYLOAD.
- PAYLOAD: line_active_o=1. Decrement the beat counter on each lane_valid_i=1. On the last beat: if frame_active_o, line_count_o+=1 (wraps at 16 bits). -> TRAIL.
- TRAIL: aligner_reset_o=1. Wait for hs_active_i=0 -> IDLE.
- hs_active_i=0 in WAIT_HDR -> IDLE, no error.
- hs_active_i=0 in PAYLOAD before the last beat -> pulse err_truncated_o, line not counted, -> IDLE.
- Watchdog: counter clears on every state change and every lane_valid_i=1. Active in WAIT_HDR and PAYLOAD. Reaching WATCHDOG_CYCLES -> pulse err_timeout_o, -> TRAIL.
- Simultaneous events:
  - Last payload beat and hs_active_i=0 in the same cycle: completes normally, line counted, no error.
  - Last payload beat and watchdog expiry in the same cycle: beat wins.

## Timing
- All outputs registered. Reset values: aligner_reset_o=1, all others 0, state IDLE.
- Asynchronous reset mid-burst discards everything; the counters are not preserved.
- HS entry at edge E: aligner_reset_o falls after edge E+1+SETTLE_CYCLES.
- Header accepted at edge H: frame_active_o / line_active_o / data_type_o update after H. Counter updates from short packets are also visible after H.
- Long packet with continuous lane_valid_i: line_active_o is high for exactly (WC+5)>>2 cycles after H. line_count_o increments on the same edge line_active_o falls.
- aligner_reset_o rises on the edge entering TRAIL.
- Error pulses are exactly one cycle, asserted on the edge of the transition.

## Test plan
- Reset, hs_active_i=1 at cycle 10 -> aligner_reset_o=1 through SETTLE, low 5 cycles later (SETTLE_CYCLES=4). All counters 0.
- Header 0x00 burst, 4 bursts of type 0x2B WC=3280, then 0x01 -> line_active_o high 821 cycles each. last_frame_lines_o=4, frame_count_o=1, frame_active_o=0.
- Long packet WC=0 -> line_active_o high 1 cycle. WC=1 -> 1 cycle. WC=3 -> 2 cycles.
- hs_active_i drops after 100 of 821 payload beats -> err_truncated_o one pulse, line_count_o unchanged, aligner_reset_o=1 next cycle.
- lane_valid_i held 0 in WAIT_HDR for 4096 cycles -> err_timeout_o pulse, state TRAIL. A second 0x00 mid-frame -> err_sequence_o pulse, line_count_o=0.
- reset_n_i asserted mid-payload -> all outputs return to reset values asynchronously. The next burst is decoded correctly.
